// File: rtl/fetch_pkg.sv
// Shared types, encodings and the per-program branch-target table for the fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned INSTR_W_DEF = 9;
  localparam int unsigned CT_W_DEF    = 16;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef enum logic [1:0] {
    CondAlways = 2'b00,
    CondEq     = 2'b01,
    CondGt     = 2'b10,
    CondLt     = 2'b11
  } branch_cond_e;

  // ALU compare flag: bit 1 set means A==B, otherwise bit 0 separates A>B from A<B.
  localparam logic [1:0] CmpGt = 2'b01;
  localparam logic [1:0] CmpLt = 2'b00;

  localparam logic [15:0] BRANCH_LUT [16] = '{
    16'h000, 16'h010, 16'h040, 16'h080, 16'h005, 16'h012, 16'h100, 16'h200,
    16'h3FF, 16'h033, 16'h0AA, 16'h155, 16'h007, 16'h00F, 16'h123, 16'h321
  };

  function automatic logic cond_true(input logic [1:0] cond, input logic [1:0] flag);
    logic res;
    unique case (cond)
      CondAlways: res = 1'b1;
      CondEq:     res = flag[1];
      CondGt:     res = (flag == CmpGt);
      default:    res = (flag == CmpLt);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational 16-entry branch-target table, truncated to the PC width.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [3:0]      i_idx,
  output logic [PC_W-1:0] o_target
);

  assign o_target = PC_W'(BRANCH_LUT[i_idx]);

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter, branch resolution, start/done handshake and run-cycle counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned CT_W    = CT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               halt_i,
  input  logic               branch_en,
  input  logic [1:0]         branch_cond,
  input  logic [3:0]         target_idx,
  input  logic [1:0]         compare_flag,
  output logic [PC_W-1:0]    prog_ctr,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid,
  output logic               done,
  output logic [CT_W-1:0]    cycle_ct
);

  state_e            r_state;
  logic [PC_W-1:0]   r_prog_ctr;
  logic              r_done;
  logic [CT_W-1:0]   r_cycle_ct;
  logic [PC_W-1:0]   w_target;
  logic              w_taken;

  branch_lut #(
    .PC_W(PC_W)
  ) u_branch_lut (
    .i_idx   (target_idx),
    .o_target(w_target)
  );

  assign w_taken = branch_en && cond_true(branch_cond, compare_flag);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_prog_ctr <= '0;
      r_done     <= 1'b0;
      r_cycle_ct <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state    <= StRun;
            r_prog_ctr <= '0;
            r_cycle_ct <= '0;
          end
        end
        StRun: begin
          // Stalled cycles still count; the counter sticks at all-ones.
          if (!(&r_cycle_ct)) r_cycle_ct <= r_cycle_ct + CT_W'(1);
          if (!stall) begin
            if (halt_i) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else if (w_taken) begin
              r_prog_ctr <= w_target;
            end else begin
              r_prog_ctr <= r_prog_ctr + PC_W'(1);
            end
          end
        end
        default: begin
          if (start) begin
            r_state    <= StRun;
            r_prog_ctr <= '0;
            r_cycle_ct <= '0;
            r_done     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign prog_ctr    = r_prog_ctr;
  assign done        = r_done;
  assign cycle_ct    = r_cycle_ct;
  assign instr_o     = instr_i;
  assign instr_valid = (r_state == StRun) && !stall;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, wrap/reset sequences, random vs model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt_i, branch_en;
  logic [8:0] instr_i;
  logic [1:0] branch_cond, compare_flag;
  logic [3:0] target_idx;
  logic [9:0] prog_ctr;
  logic [8:0] instr_o;
  logic       instr_valid, done;
  logic [15:0] cycle_ct;

  logic       n_reset, n_start;
  logic [3:0] n_pc;
  logic [8:0] n_instr_o;
  logic       n_valid, n_done;
  logic [15:0] n_ct;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .instr_i(instr_i),
    .halt_i(halt_i), .branch_en(branch_en), .branch_cond(branch_cond),
    .target_idx(target_idx), .compare_flag(compare_flag), .prog_ctr(prog_ctr),
    .instr_o(instr_o), .instr_valid(instr_valid), .done(done), .cycle_ct(cycle_ct)
  );

  fetch_ctrl #(.PC_W(4), .INSTR_W(9), .CT_W(16)) u_narrow (
    .clk(clk), .reset(n_reset), .start(n_start), .stall(1'b0), .instr_i(9'h0),
    .halt_i(1'b0), .branch_en(1'b0), .branch_cond(2'b00), .target_idx(4'h0),
    .compare_flag(2'b00), .prog_ctr(n_pc), .instr_o(n_instr_o), .instr_valid(n_valid),
    .done(n_done), .cycle_ct(n_ct)
  );

  typedef struct {
    logic        start, stall, halt, br;
    logic [1:0]  cond;
    logic [3:0]  idx;
    logic [1:0]  flag;
    logic        exp_valid;
    logic [9:0]  exp_pc;
    logic        exp_done;
    logic [15:0] exp_ct;
  } vec_t;

  logic [9:0] lut [16] = '{
    10'h000, 10'h010, 10'h040, 10'h080, 10'h005, 10'h012, 10'h100, 10'h200,
    10'h3FF, 10'h033, 10'h0AA, 10'h155, 10'h007, 10'h00F, 10'h123, 10'h321
  };

  // Reference model state: 0 idle, 1 run, 2 done.
  int m_st, m_pc, m_ct;
  bit m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(logic s, logic st, logic h, logic b, logic [1:0] c,
                              logic [3:0] i, logic [1:0] f, logic v, logic [9:0] pc,
                              logic d, logic [15:0] ct);
    vec_t r;
    r.start = s; r.stall = st; r.halt = h; r.br = b; r.cond = c; r.idx = i; r.flag = f;
    r.exp_valid = v; r.exp_pc = pc; r.exp_done = d; r.exp_ct = ct;
    return r;
  endfunction

  function automatic bit ref_taken(int cond, int flag);
    case (cond)
      0:       return 1'b1;
      1:       return flag >= 2;
      2:       return flag == 1;
      default: return flag == 0;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_st = 0; m_pc = 0; m_ct = 0; m_done = 0;
    end else if (m_st == 0) begin
      if (start) begin m_st = 1; m_pc = 0; m_ct = 0; end
    end else if (m_st == 1) begin
      if (m_ct < 65535) m_ct++;
      if (!stall) begin
        if (halt_i) begin m_st = 2; m_done = 1; end
        else if (branch_en && ref_taken(branch_cond, compare_flag)) m_pc = lut[target_idx];
        else m_pc = (m_pc + 1) % 1024;
      end
    end else if (start) begin
      m_st = 1; m_pc = 0; m_ct = 0; m_done = 0;
    end
  endtask

  task automatic drive(input vec_t v);
    start = v.start; stall = v.stall; halt_i = v.halt; branch_en = v.br;
    branch_cond = v.cond; target_idx = v.idx; compare_flag = v.flag;
    instr_i = 9'($urandom);
  endtask

  vec_t tbl[18];

  initial begin
    reset = 1'b1; start = 0; stall = 0; halt_i = 0; branch_en = 0;
    branch_cond = 0; target_idx = 0; compare_flag = 0; instr_i = 0;
    n_reset = 1'b1; n_start = 0;

    tbl[0]  = mk(1, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 10'h000, 0, 16'd0);
    tbl[1]  = mk(0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 10'h001, 0, 16'd1);
    tbl[2]  = mk(0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 10'h002, 0, 16'd2);
    tbl[3]  = mk(0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 10'h003, 0, 16'd3);
    tbl[4]  = mk(0, 0, 0, 1, 2'b01, 4'd2, 2'b10, 1, 10'h040, 0, 16'd4);
    tbl[5]  = mk(0, 0, 0, 1, 2'b01, 4'd2, 2'b01, 1, 10'h041, 0, 16'd5);
    tbl[6]  = mk(0, 0, 0, 1, 2'b11, 4'd4, 2'b00, 1, 10'h005, 0, 16'd6);
    tbl[7]  = mk(0, 1, 0, 1, 2'b00, 4'd1, 2'b00, 0, 10'h005, 0, 16'd7);
    tbl[8]  = mk(0, 1, 0, 1, 2'b00, 4'd1, 2'b00, 0, 10'h005, 0, 16'd8);
    tbl[9]  = mk(0, 0, 0, 1, 2'b00, 4'd1, 2'b00, 1, 10'h010, 0, 16'd9);
    tbl[10] = mk(0, 0, 0, 1, 2'b11, 4'd1, 2'b01, 1, 10'h011, 0, 16'd10);
    tbl[11] = mk(0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 10'h012, 0, 16'd11);
    tbl[12] = mk(0, 0, 1, 0, 2'b00, 4'd0, 2'b00, 1, 10'h012, 1, 16'd12);
    tbl[13] = mk(0, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 10'h012, 1, 16'd12);
    tbl[14] = mk(1, 0, 0, 0, 2'b00, 4'd0, 2'b00, 0, 10'h000, 0, 16'd0);
    tbl[15] = mk(1, 0, 0, 0, 2'b00, 4'd0, 2'b00, 1, 10'h001, 0, 16'd1);
    tbl[16] = mk(0, 0, 0, 1, 2'b10, 4'd3, 2'b01, 1, 10'h080, 0, 16'd2);
    tbl[17] = mk(0, 0, 0, 1, 2'b01, 4'd5, 2'b11, 1, 10'h012, 0, 16'd3);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(prog_ctr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ct", 32'(cycle_ct), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k]);
      #3;
      chk($sformatf("v%0d_valid", k), 32'(instr_valid), 32'(tbl[k].exp_valid));
      chk($sformatf("v%0d_instr", k), 32'(instr_o), 32'(instr_i));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", k), 32'(prog_ctr), 32'(tbl[k].exp_pc));
      chk($sformatf("v%0d_done", k), 32'(done), 32'(tbl[k].exp_done));
      chk($sformatf("v%0d_ct", k), 32'(cycle_ct), 32'(tbl[k].exp_ct));
    end

    // Mid-run reset wins over a simultaneous start.
    start = 1; reset = 1; branch_en = 0;
    @(posedge clk); #1;
    chk("midrst_pc", 32'(prog_ctr), 0);
    chk("midrst_ct", 32'(cycle_ct), 0);
    chk("midrst_done", 32'(done), 0);
    start = 0; reset = 0;
    #3 chk("midrst_valid", 32'(instr_valid), 0);
    @(posedge clk); #1;
    chk("idle_pc", 32'(prog_ctr), 0);
    chk("idle_ct", 32'(cycle_ct), 0);

    // Narrow PC wraps from 0xF to 0x0.
    n_reset = 0; n_start = 1;
    @(posedge clk); #1;
    n_start = 0;
    chk("nar_start_pc", 32'(n_pc), 0);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      chk($sformatf("nar_pc%0d", i), 32'(n_pc), 32'(i % 16));
    end
    chk("nar_valid", 32'(n_valid), 1);

    // Randomised run against the model.
    reset = 1; start = 0; stall = 0; halt_i = 0;
    @(posedge clk); #1;
    model_edge();
    reset = 0;
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      halt_i       = ($urandom_range(0, 24) == 0);
      branch_en    = ($urandom_range(0, 3) == 0);
      branch_cond  = 2'($urandom);
      target_idx   = 4'($urandom);
      compare_flag = 2'($urandom);
      instr_i      = 9'($urandom);
      #3;
      chk("rnd_valid", 32'(instr_valid), 32'(m_st == 1 && !stall));
      chk("rnd_instr", 32'(instr_o), 32'(instr_i));
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd_pc", 32'(prog_ctr), 32'(m_pc));
      chk("rnd_done", 32'(done), 32'(m_done));
      chk("rnd_ct", 32'(cycle_ct), 32'(m_ct));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
